// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: sequences product-deliver and coin-return actions.
// Requests are queued in two saturating 2-bit counters; a single FSM drives
// the product motor or the coin solenoid for PULSE_CYC cycles, confirms each
// product drop within TIMEOUT_CYC cycles, and parks in FAULT on a missed drop.
// Optional feature: define VEND_STAT_EN to add the vend_total[15:0] counter
// of confirmed vends.
module vend_dispense_ctrl #(
  parameter int PULSE_CYC   = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vend_req,
  input  logic        chg_req,
  input  logic        drop_sense,
  input  logic        fault_clr,
  output logic        motor_on,
  output logic        coin_sol,
  output logic        vend_done,
  output logic        chg_done,
  output logic        busy,
  output logic        fault,
`ifdef VEND_STAT_EN
  output logic        ovf,
  output logic [15:0] vend_total
`else
  output logic        ovf
`endif
);

  localparam int TMAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] PULSE_LD   = TW'(PULSE_CYC);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_ONE      = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_WAIT_DROP,
    S_COIN,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    vend_pend_q, vend_pend_d;
  logic [1:0]    chg_pend_q, chg_pend_d;
  logic          drop_seen_q, drop_seen_d;
  logic          motor_on_q, motor_on_d;
  logic          coin_sol_q, coin_sol_d;
  logic          vend_done_q, vend_done_d;
  logic          chg_done_q, chg_done_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic          ovf_q, ovf_d;
  logic          vend_take, chg_take;
  logic          vend_inc, chg_inc, vend_ovf, chg_ovf;

  // Next-state logic: launch queued work from IDLE, time each action.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    timer_d     = timer_q;
    drop_seen_d = drop_seen_q;
    vend_take   = 1'b0;
    chg_take    = 1'b0;
    vend_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Product has priority over change.
        if (vend_pend_q != 2'd0) begin
          state_d     = S_MOTOR;
          vend_take   = 1'b1;
          timer_d     = PULSE_LD;
          drop_seen_d = 1'b0;
        end else if (chg_pend_q != 2'd0) begin
          state_d  = S_COIN;
          chg_take = 1'b1;
          timer_d  = PULSE_LD;
        end
      end
      S_MOTOR: begin
        // A product can fall while the motor is still turning.
        if (drop_sense) drop_seen_d = 1'b1;
        if (timer_q == T_ONE) begin
          state_d = S_WAIT_DROP;
          timer_d = TIMEOUT_LD;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_WAIT_DROP: begin
        if (drop_seen_q || drop_sense) begin
          vend_done_d = 1'b1;
          state_d     = S_IDLE;
          timer_d     = '0;
        end else if (timer_q == T_ONE) begin
          state_d = S_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_COIN: begin
        if (timer_q == T_ONE) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Request queues and registered-output precomputation from next state.
  always_comb begin
    vend_ovf = vend_req && (vend_pend_q == 2'd3);
    chg_ovf  = chg_req && (chg_pend_q == 2'd3);
    vend_inc = vend_req && !vend_ovf;
    chg_inc  = chg_req && !chg_ovf;

    unique case ({vend_inc, vend_take})
      2'b10:   vend_pend_d = vend_pend_q + 2'd1;
      2'b01:   vend_pend_d = vend_pend_q - 2'd1;
      default: vend_pend_d = vend_pend_q;
    endcase
    unique case ({chg_inc, chg_take})
      2'b10:   chg_pend_d = chg_pend_q + 2'd1;
      2'b01:   chg_pend_d = chg_pend_q - 2'd1;
      default: chg_pend_d = chg_pend_q;
    endcase

    ovf_d      = ovf_q | vend_ovf | chg_ovf;
    motor_on_d = (state_d == S_MOTOR);
    coin_sol_d = (state_d == S_COIN);
    fault_d    = (state_d == S_FAULT);
    // chg_done coincides with the final solenoid cycle.
    chg_done_d = (state_d == S_COIN) && (timer_d == T_ONE);
    busy_d     = (state_d != S_IDLE) || (vend_pend_d != 2'd0) || (chg_pend_d != 2'd0);
  end

  // State, queue and output registers; reset drops actuators immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      vend_pend_q <= 2'd0;
      chg_pend_q  <= 2'd0;
      drop_seen_q <= 1'b0;
      motor_on_q  <= 1'b0;
      coin_sol_q  <= 1'b0;
      vend_done_q <= 1'b0;
      chg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      vend_pend_q <= vend_pend_d;
      chg_pend_q  <= chg_pend_d;
      drop_seen_q <= drop_seen_d;
      motor_on_q  <= motor_on_d;
      coin_sol_q  <= coin_sol_d;
      vend_done_q <= vend_done_d;
      chg_done_q  <= chg_done_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      ovf_q       <= ovf_d;
    end
  end

  assign motor_on  = motor_on_q;
  assign coin_sol  = coin_sol_q;
  assign vend_done = vend_done_q;
  assign chg_done  = chg_done_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign ovf       = ovf_q;

`ifdef VEND_STAT_EN
  logic [15:0] vend_total_q, vend_total_d;

  // Count confirmed vends, one cycle after each vend_done pulse; wraps.
  always_comb begin
    vend_total_d = vend_total_q + 16'(vend_done_q);
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vend_total_q <= 16'd0;
    else      vend_total_q <= vend_total_d;
  end

  assign vend_total = vend_total_q;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl. Stimulus pushes the expected
// output events (actuator edges, done pulses, fault edges) with the cycle they
// must appear in; a negedge monitor pops and compares whenever the DUT shows one.
module tb_vend_dispense_ctrl;

  localparam int PULSE_CYC   = 8;
  localparam int TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vend_req = 1'b0, chg_req = 1'b0, drop_sense = 1'b0, fault_clr = 1'b0;
  logic motor_on, coin_sol, vend_done, chg_done, busy, fault, ovf;
`ifdef VEND_STAT_EN
  logic [15:0] vend_total;
`endif

  vend_dispense_ctrl #(.PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .vend_req   (vend_req),
    .chg_req    (chg_req),
    .drop_sense (drop_sense),
    .fault_clr  (fault_clr),
    .motor_on   (motor_on),
    .coin_sol   (coin_sol),
    .vend_done  (vend_done),
    .chg_done   (chg_done),
    .busy       (busy),
    .fault      (fault),
`ifdef VEND_STAT_EN
    .ovf        (ovf),
    .vend_total (vend_total)
`else
    .ovf        (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int excl  = 0;

  typedef enum int {
    EV_MOTOR_RISE, EV_MOTOR_FALL, EV_COIN_RISE, EV_COIN_FALL,
    EV_VEND_DONE, EV_CHG_DONE, EV_FAULT_RISE, EV_FAULT_FALL
  } ev_e;

  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input ev_e k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind(exp %s)", e.kind.name()), int'(k), int'(e.kind));
      check($sformatf("%s_cycle", e.kind.name()), cyc, e.cyc);
    end
  endtask

  // Monitor: samples at negedge, turns output edges/pulses into events.
  initial begin
    logic m_p, c_p, f_p;
    m_p = 1'b0;
    c_p = 1'b0;
    f_p = 1'b0;
    forever begin
      @(negedge clk);
      if (motor_on && coin_sol) excl++;
      if (motor_on && !m_p) observe(EV_MOTOR_RISE);
      if (!motor_on && m_p) observe(EV_MOTOR_FALL);
      if (coin_sol && !c_p) observe(EV_COIN_RISE);
      if (!coin_sol && c_p) observe(EV_COIN_FALL);
      if (vend_done)        observe(EV_VEND_DONE);
      if (chg_done)         observe(EV_CHG_DONE);
      if (fault && !f_p)    observe(EV_FAULT_RISE);
      if (!fault && f_p)    observe(EV_FAULT_FALL);
      m_p = motor_on;
      c_p = coin_sol;
      f_p = fault;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Drive vend_req for the current cycle only.
  task automatic pulse_vend();
    vend_req = 1'b1;
    tick();
    vend_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;

    // Reset state.
    repeat (3) tick();
    check("rst_motor_on", motor_on, 0);
    check("rst_coin_sol", coin_sol, 0);
    check("rst_vend_done", vend_done, 0);
    check("rst_chg_done", chg_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Test 1: single vend, drop sensed in WAIT_DROP at cycle 12.
    t0 = cyc;
    expect_ev(EV_MOTOR_RISE, t0 + 2);
    expect_ev(EV_MOTOR_FALL, t0 + 10);
    expect_ev(EV_VEND_DONE,  t0 + 13);
    pulse_vend();
    check("t1_busy_after_req", busy, 1);
    run_to(t0 + 12);
    drop_sense = 1'b1;
    tick();
    drop_sense = 1'b0;
    run_to(t0 + 14);
    check("t1_busy_idle", busy, 0);
    check("t1_events_left", exp_q.size(), 0);

    // Test 2: vend and change together; product first, one IDLE cycle, then coin.
    t0 = cyc;
    expect_ev(EV_MOTOR_RISE, t0 + 2);
    expect_ev(EV_MOTOR_FALL, t0 + 10);
    expect_ev(EV_VEND_DONE,  t0 + 11);
    expect_ev(EV_COIN_RISE,  t0 + 12);
    expect_ev(EV_CHG_DONE,   t0 + 19);
    expect_ev(EV_COIN_FALL,  t0 + 20);
    vend_req = 1'b1;
    chg_req  = 1'b1;
    tick();
    vend_req = 1'b0;
    chg_req  = 1'b0;
    run_to(t0 + 5);
    drop_sense = 1'b1;
    tick();
    drop_sense = 1'b0;
    run_to(t0 + 24);
    check("t2_busy_idle", busy, 0);
    check("t2_events_left", exp_q.size(), 0);

    // Test 3: four extra vend_req during MOTOR -> queue saturates, ovf, 4 sequences total.
    t0 = cyc;
    drop_sense = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_ev(EV_MOTOR_RISE, t0 + 2 + 10 * k);
      expect_ev(EV_MOTOR_FALL, t0 + 10 + 10 * k);
      expect_ev(EV_VEND_DONE,  t0 + 11 + 10 * k);
    end
    pulse_vend();
    for (int k = 0; k < 4; k++) begin
      run_to(t0 + 3 + k);
      if (k == 3) check("t3_ovf_before_overflow", ovf, 0);
      pulse_vend();
    end
    check("t3_ovf_set", ovf, 1);
    run_to(t0 + 45);
    drop_sense = 1'b0;
    check("t3_busy_idle", busy, 0);
    check("t3_events_left", exp_q.size(), 0);

    // Test 4: no drop -> FAULT after 64 WAIT_DROP cycles; coin request queued in FAULT.
    t0 = cyc;
    expect_ev(EV_MOTOR_RISE, t0 + 2);
    expect_ev(EV_MOTOR_FALL, t0 + 10);
    expect_ev(EV_FAULT_RISE, t0 + 74);
    pulse_vend();
    run_to(t0 + 73);
    check("t4_fault_before_timeout", fault, 0);
    tick();
    check("t4_fault_at_timeout", fault, 1);
    run_to(t0 + 78);
    chg_req = 1'b1;
    tick();
    chg_req = 1'b0;
    run_to(t0 + 81);
    check("t4_fault_held", fault, 1);
    check("t4_coin_held_in_fault", coin_sol, 0);
    check("t4_busy_in_fault", busy, 1);
    expect_ev(EV_FAULT_FALL, t0 + 83);
    expect_ev(EV_COIN_RISE,  t0 + 84);
    expect_ev(EV_CHG_DONE,   t0 + 91);
    expect_ev(EV_COIN_FALL,  t0 + 92);
    run_to(t0 + 82);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    run_to(t0 + 95);
    check("t4_fault_cleared", fault, 0);
    check("t4_busy_idle", busy, 0);
    check("t4_ovf_sticky", ovf, 1);
    check("t4_events_left", exp_q.size(), 0);

    // Test 5: asynchronous reset mid-MOTOR with two vends queued.
    t0 = cyc;
    expect_ev(EV_MOTOR_RISE, t0 + 2);
    pulse_vend();
    run_to(t0 + 3);
    pulse_vend();
    pulse_vend();
    run_to(t0 + 6);
    check("t5_motor_before_rst", motor_on, 1);
    expect_ev(EV_MOTOR_FALL, t0 + 6);
    #1;
    rst = 1'b0;
    #1;
    check("t5_motor_async_off", motor_on, 0);
    check("t5_ovf_async_clear", ovf, 0);
    check("t5_busy_async_clear", busy, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (40) tick();
    check("t5_motor_idle", motor_on, 0);
    check("t5_coin_idle", coin_sol, 0);
    check("t5_busy_idle", busy, 0);
    check("t5_fault_idle", fault, 0);
    check("t5_ovf_idle", ovf, 0);
    check("t5_events_left", exp_q.size(), 0);

`ifdef VEND_STAT_EN
    // Test 6: statistics counter counts confirmed vends and wraps.
    check("t6_total_reset", vend_total, 0);
    t0 = cyc;
    drop_sense = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_ev(EV_MOTOR_RISE, t0 + 2 + 10 * k);
      expect_ev(EV_MOTOR_FALL, t0 + 10 + 10 * k);
      expect_ev(EV_VEND_DONE,  t0 + 11 + 10 * k);
    end
    for (int k = 0; k < 3; k++) pulse_vend();
    run_to(t0 + 33);
    check("t6_total_three", vend_total, 3);
    force dut.vend_total_q = 16'hFFFF;
    #1;
    release dut.vend_total_q;
    t0 = cyc;
    expect_ev(EV_MOTOR_RISE, t0 + 2);
    expect_ev(EV_MOTOR_FALL, t0 + 10);
    expect_ev(EV_VEND_DONE,  t0 + 11);
    pulse_vend();
    run_to(t0 + 11);
    check("t6_total_preload", vend_total, 16'hFFFF);
    run_to(t0 + 13);
    check("t6_total_wrap", vend_total, 0);
    drop_sense = 1'b0;
    check("t6_events_left", exp_q.size(), 0);
`endif

    check("actuator_exclusion_violations", excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
